// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter among
// up to 16 byte-stream requesters, with optional channel tag and watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter bit          TAG_EN  = 1'b1,
    parameter logic [31:0] TIMEOUT = 32'd65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [3:0]           grant_id,
    output logic                 active,
    output logic                 timeout_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        FETCH,
        SEND,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [3:0]  ptr;
    logic [3:0]  ptrNext;
    logic [3:0]  grantNext;
    logic [3:0]  wrapNext;
    logic [7:0]  txDataNext;
    logic        lastQ;
    logic        lastNext;
    logic        afterTag;
    logic        afterTagNext;
    logic        toNext;
    logic [31:0] wdog;
    logic [31:0] wdogNext;
    logic [31:0] wdogInc;

    logic        hit;
    logic [3:0]  hitId;
    logic [4:0]  idx;
    logic        curValid;
    logic        curLast;
    logic [7:0]  curData;

    // Round-robin search from ptr; wrap by compare-and-subtract so any NUM_REQ works.
    always_comb begin
        hit   = 1'b0;
        hitId = ptr;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= 5'(NUM_REQ)) begin
                idx = idx - 5'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!hit && idx == 5'(j) && req_valid[j]) begin
                    hit   = 1'b1;
                    hitId = 4'(j);
                end
            end
        end
    end

    always_comb begin
        curValid = 1'b0;
        curLast  = 1'b0;
        curData  = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_id == 4'(j)) begin
                curValid = req_valid[j];
                curLast  = req_last[j];
                curData  = req_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == FETCH) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (grant_id == 4'(j)) begin
                    req_ready[j] = 1'b1;
                end
            end
        end
    end

    assign wrapNext = (grant_id == 4'(NUM_REQ - 1)) ? 4'd0 : grant_id + 4'd1;
    assign wdogInc  = wdog + 32'd1;
    assign active   = (state != IDLE);
    // Starts are gated by busy so a transmitter still busy after reset is never re-triggered.
    assign tx_start = ((state == TAG) || (state == SEND)) && !tx_busy;

    always_comb begin
        stateNext    = state;
        ptrNext      = ptr;
        grantNext    = grant_id;
        txDataNext   = tx_data;
        lastNext     = lastQ;
        afterTagNext = afterTag;
        wdogNext     = '0;
        toNext       = 1'b0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    grantNext = hitId;
                    if (TAG_EN) begin
                        txDataNext = {4'hA, hitId};
                        stateNext  = TAG;
                    end else begin
                        stateNext = FETCH;
                    end
                end
            end
            TAG: begin
                if (!tx_busy) begin
                    afterTagNext = 1'b1;
                    stateNext    = HOLD;
                end
            end
            FETCH: begin
                if (curValid) begin
                    txDataNext = curData;
                    lastNext   = curLast;
                    stateNext  = SEND;
                end else if (wdogInc == TIMEOUT) begin
                    toNext    = 1'b1;
                    ptrNext   = wrapNext;
                    stateNext = IDLE;
                end else begin
                    wdogNext = wdogInc;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    afterTagNext = 1'b0;
                    stateNext    = HOLD;
                end
            end
            HOLD: begin
                stateNext = DRAIN;
            end
            DRAIN: begin
                if (!tx_busy) begin
                    if (afterTag) begin
                        stateNext = FETCH;
                    end else if (lastQ) begin
                        ptrNext   = wrapNext;
                        stateNext = IDLE;
                    end else begin
                        stateNext = FETCH;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            grant_id      <= '0;
            tx_data       <= '0;
            lastQ         <= 1'b0;
            afterTag      <= 1'b0;
            wdog          <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= stateNext;
            ptr           <= ptrNext;
            grant_id      <= grantNext;
            tx_data       <= txDataNext;
            lastQ         <= lastNext;
            afterTag      <= afterTagNext;
            wdog          <= wdogNext;
            timeout_pulse <= toNext;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: three configurations, each with a
// stub transmitter (10-cycle busy) and queue-driven requesters.
module tb_uart_tx_arbiter;

    localparam int BUSY = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [6:0]  laneValid;
    logic [6:0]  laneLast;
    logic [6:0]  laneReady;
    logic [55:0] laneData;
    logic [2:0]  startV;
    logic [2:0]  busyV;
    logic [2:0]  activeV;
    logic [2:0]  toV;
    logic [23:0] dataV;
    logic [11:0] grantV;

    int   busyCnt[3]   = '{0, 0, 0};
    int   viol[3]      = '{0, 0, 0};
    int   consec[3]    = '{0, 0, 0};
    int   toCnt[3]     = '{0, 0, 0};
    int   toCyc[3]     = '{0, 0, 0};
    logic prevStart[3] = '{1'b0, 1'b0, 1'b0};
    int   cyc          = 0;

    logic [7:0] logQ[3][$];
    int         stCyc[3][$];
    logic [8:0] lq[7][$];

    int nTests = 0;
    int nFail  = 0;

    uart_tx_arbiter #(.NUM_REQ(2), .TAG_EN(1'b1), .TIMEOUT(32'd100)) dutA (
        .clk(clk), .rst(rst),
        .req_valid(laneValid[1:0]), .req_data(laneData[15:0]),
        .req_last(laneLast[1:0]), .req_ready(laneReady[1:0]),
        .tx_start(startV[0]), .tx_data(dataV[7:0]), .tx_busy(busyV[0]),
        .grant_id(grantV[3:0]), .active(activeV[0]), .timeout_pulse(toV[0])
    );

    uart_tx_arbiter #(.NUM_REQ(2), .TAG_EN(1'b1), .TIMEOUT(32'd8)) dutB (
        .clk(clk), .rst(rst),
        .req_valid(laneValid[3:2]), .req_data(laneData[31:16]),
        .req_last(laneLast[3:2]), .req_ready(laneReady[3:2]),
        .tx_start(startV[1]), .tx_data(dataV[15:8]), .tx_busy(busyV[1]),
        .grant_id(grantV[7:4]), .active(activeV[1]), .timeout_pulse(toV[1])
    );

    uart_tx_arbiter #(.NUM_REQ(3), .TAG_EN(1'b0), .TIMEOUT(32'd100)) dutC (
        .clk(clk), .rst(rst),
        .req_valid(laneValid[6:4]), .req_data(laneData[55:32]),
        .req_last(laneLast[6:4]), .req_ready(laneReady[6:4]),
        .tx_start(startV[2]), .tx_data(dataV[23:16]), .tx_busy(busyV[2]),
        .grant_id(grantV[11:8]), .active(activeV[2]), .timeout_pulse(toV[2])
    );

    assign busyV = {busyCnt[2] != 0, busyCnt[1] != 0, busyCnt[0] != 0};

    // Stub transmitters and start/timeout monitors
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 3; g++) begin
            if (startV[g]) begin
                if (busyV[g]) viol[g] <= viol[g] + 1;
                if (prevStart[g]) consec[g] <= consec[g] + 1;
                logQ[g].push_back(dataV[g*8 +: 8]);
                stCyc[g].push_back(cyc);
                busyCnt[g] <= BUSY;
            end else if (busyCnt[g] != 0) begin
                busyCnt[g] <= busyCnt[g] - 1;
            end
            prevStart[g] <= startV[g];
            if (toV[g]) begin
                toCnt[g] <= toCnt[g] + 1;
                toCyc[g] <= cyc;
            end
        end
    end

    // Requester model: pop on handshake, present queue head shortly after the edge
    always @(posedge clk) begin
        for (int l = 0; l < 7; l++) begin
            if (laneValid[l] && laneReady[l] && lq[l].size() > 0) begin
                void'(lq[l].pop_front());
            end
        end
        #1;
        for (int l = 0; l < 7; l++) begin
            if (lq[l].size() > 0) begin
                laneValid[l]        = 1'b1;
                laneLast[l]         = lq[l][0][8];
                laneData[l*8 +: 8]  = lq[l][0][7:0];
            end else begin
                laneValid[l]        = 1'b0;
                laneLast[l]         = 1'b0;
                laneData[l*8 +: 8]  = 8'h00;
            end
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkSeq(int g, string tag, int n, logic [63:0] exp);
        check({tag, "_len"}, logQ[g].size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < logQ[g].size()) begin
                check($sformatf("%s_b%0d", tag, i), logQ[g][i], exp[(n-1-i)*8 +: 8]);
            end
        end
    endtask

    task automatic clearLog(int g);
        logQ[g].delete();
        stCyc[g].delete();
    endtask

    task automatic waitDone(int g, int lo, int hi, int maxc);
        int  n  = 0;
        bit  ok = 1'b0;
        while (!ok && n < maxc) begin
            @(negedge clk);
            n++;
            ok = !activeV[g] && !busyV[g];
            for (int l = lo; l <= hi; l++) begin
                if (lq[l].size() != 0 || laneValid[l]) ok = 1'b0;
            end
        end
        if (!ok) check($sformatf("wait_done_%0d", g), 0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        laneValid = '0;
        laneLast  = '0;
        laneData  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_active", activeV, 3'b000);
        check("rst_start", startV, 3'b000);
        check("rst_data", dataV, 24'h0);
        check("rst_grant", grantV, 12'h0);
        check("rst_ready", laneReady, 7'h0);
        check("rst_timeout", toV, 3'b000);
        rst = 1'b0;

        // Single tagged packet
        lq[0].push_back(9'h011);
        lq[0].push_back(9'h022);
        lq[0].push_back(9'h133);
        waitDone(0, 0, 1, 400);
        checkSeq(0, "single", 4, 64'hA0112233);
        if (stCyc[0].size() >= 2) check("single_gap", stCyc[0][1] - stCyc[0][0], 13);
        check("single_active", activeV[0], 1'b0);

        // Contention from a fresh pointer
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clearLog(0);
        lq[0].push_back(9'h001);
        lq[0].push_back(9'h102);
        lq[1].push_back(9'h081);
        lq[1].push_back(9'h182);
        waitDone(0, 0, 1, 400);
        checkSeq(0, "cont1", 6, 64'hA00102A18182);
        if (stCyc[0].size() >= 4) check("cont1_gap", stCyc[0][3] - stCyc[0][2], 13);
        clearLog(0);
        lq[0].push_back(9'h003);
        lq[0].push_back(9'h104);
        lq[1].push_back(9'h083);
        lq[1].push_back(9'h184);
        waitDone(0, 0, 1, 400);
        checkSeq(0, "cont2", 6, 64'hA00304A18384);

        // Back-pressure shorter than the watchdog
        clearLog(0);
        lq[0].push_back(9'h031);
        for (int n = 0; n < 50 && lq[0].size() != 0; n++) @(negedge clk);
        check("bp_popped", lq[0].size(), 0);
        repeat (50) @(negedge clk);
        check("bp_active", activeV[0], 1'b1);
        check("bp_ready", laneReady[0], 1'b1);
        lq[0].push_back(9'h032);
        lq[0].push_back(9'h133);
        waitDone(0, 0, 1, 400);
        checkSeq(0, "bp", 4, 64'hA0313233);
        check("bp_no_timeout", toCnt[0], 0);

        // Reset while the transmitter is mid-byte
        clearLog(0);
        lq[1].push_back(9'h091);
        lq[1].push_back(9'h192);
        for (int n = 0; n < 50 && stCyc[0].size() == 0; n++) @(negedge clk);
        check("rstm_tag_seen", stCyc[0].size(), 1);
        @(negedge clk);
        rst = 1'b1;
        lq[1].delete();
        @(negedge clk);
        check("rstm_active", activeV[0], 1'b0);
        check("rstm_start", startV[0], 1'b0);
        check("rstm_data", dataV[7:0], 8'h00);
        check("rstm_grant", grantV[3:0], 4'h0);
        check("rstm_ready", laneReady[1:0], 2'b00);
        clearLog(0);
        lq[1].push_back(9'h091);
        lq[1].push_back(9'h192);
        rst = 1'b0;
        waitDone(0, 0, 1, 400);
        checkSeq(0, "rstm", 3, 64'hA19192);

        // Watchdog release with another requester pending
        clearLog(1);
        lq[2].push_back(9'h041);
        lq[3].push_back(9'h151);
        waitDone(1, 2, 3, 400);
        checkSeq(1, "to", 4, 64'hA041A151);
        check("to_count", toCnt[1], 1);
        if (stCyc[1].size() >= 3) begin
            check("to_delay", toCyc[1] - stCyc[1][1], 20);
            check("to_next_tag", stCyc[1][2] - toCyc[1], 1);
        end

        // Untagged single byte, then pointer wrap
        clearLog(2);
        lq[6].push_back(9'h15A);
        waitDone(2, 4, 6, 200);
        checkSeq(2, "untag", 1, 64'h5A);
        check("untag_grant", grantV[11:8], 4'd2);
        clearLog(2);
        lq[5].push_back(9'h161);
        lq[6].push_back(9'h171);
        waitDone(2, 4, 6, 200);
        checkSeq(2, "wrap", 2, 64'h6171);

        for (int g = 0; g < 3; g++) begin
            check($sformatf("start_busy_%0d", g), viol[g], 0);
            check($sformatf("start_b2b_%0d", g), consec[g], 0);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
